// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 column-scanned keypad with frame debounce, key-state level map and press-event handshake.
module keypad_scanner #(
  parameter int SETTLE_CYCLES = 1000,
  parameter int STABLE_SCANS  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ready,
  output logic [15:0] key_state,
  output logic        overflow
);
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int CW = $clog2(STABLE_SCANS);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_SCANS - 1);
  logic [3:0]    r_sync1, r_sync2;
  logic [1:0]    r_col;
  logic [SW-1:0] r_settle;
  logic [15:0]   r_frame, r_cand;
  logic [CW-1:0] r_stable;
  logic          r_commit;
  logic          w_sample, w_frame_end, w_event;
  logic [15:0]   w_frame, w_new;
  logic [3:0]    w_code;
  assign col_n       = ~(4'b0001 << r_col);
  assign w_sample    = r_settle == '0;
  assign w_frame_end = w_sample && r_col == 2'd3;
  assign w_new       = r_cand & ~key_state;
  assign w_event     = r_commit && |w_new;
  // Frame as it will look once the current column's sample is written in.
  always_comb begin
    w_frame = r_frame;
    w_frame[{r_col, 2'b00} +: 4] = r_sync2;
  end
  always_comb begin
    w_code = '0;
    for (int i = 15; i >= 0; i--) if (w_new[i]) w_code = 4'(i);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_col     <= '0;
      r_settle  <= SETTLE_MAX;
      r_frame   <= '0;
      r_cand    <= '0;
      r_stable  <= '0;
      r_commit  <= 1'b0;
      key_state <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      r_sync1  <= ~row_n;
      r_sync2  <= r_sync1;
      r_settle <= w_sample ? SETTLE_MAX : r_settle - 1'b1;
      if (w_sample) begin
        r_frame <= w_frame;
        r_col   <= r_col + 1'b1;
      end
      r_commit <= w_frame_end && w_frame == r_cand && r_stable == STABLE_MAX;
      if (w_frame_end) begin
        if (w_frame != r_cand) begin
          r_cand   <= w_frame;
          r_stable <= '0;
        end else if (r_stable != STABLE_MAX) r_stable <= r_stable + 1'b1;
      end
      if (r_commit) key_state <= r_cand;
      // A pending unaccepted event wins; a newer one is dropped and flagged.
      overflow <= w_event && key_valid && !key_ready;
      if (w_event && (!key_valid || key_ready)) begin
        key_code  <= w_code;
        key_valid <= 1'b1;
      end else if (key_ready) key_valid <= 1'b0;
    end
  end
endmodule
